dx_route: RTL and testbench
===========================

Name: dx_route

Overview:
- Parametrised 1:N registered demultiplexer with valid/ready handshake.
- Steers a WIDTH-bit word to one of NCH consumers (e.g. ch0 = ALU operand path, ch1 = data-memory address path, further channels for new units).
- Each channel has a one-entry output register, so the source sees per-channel backpressure.
- Unused outputs drive zero.

Parameters:
- WIDTH, 32, data word width in bits.
- NCH, 2, number of output channels (2..16).
- SEL_W, derived localparam = max(1, clog2(NCH)), select width; not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  source has a word.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  WIDTH  word to route.
- in_sel  in  SEL_W  destination channel index.
- out_valid  out  NCH  bit k: channel k holds a word.
- out_ready  in  NCH  bit k: consumer k takes the word.
- out_data  out  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
- sel_err  out  1  sticky flag: an out-of-range select was accepted.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: out_valid = 0, all out_data = 0, sel_err = 0.
  - Reset mid-operation discards all buffered words. Nothing is delivered afterwards.
- Channel slot k: each slot is either EMPTY or FULL.
  - EMPTY -> FULL on accept with in_sel == k.
  - FULL -> EMPTY on out_ready[k] with no new accept for k.
  - FULL stays FULL on drain plus accept for k in the same cycle. The new word replaces the old; throughput is 1 word/cycle.
- in_ready rules:
  - in_sel < NCH: in_ready = !out_valid[in_sel] || out_ready[in_sel]. This is combinational from in_sel and out_ready; no path from in_valid.
  - in_sel >= NCH (only possible when NCH is not a power of 2): in_ready = 1.
- Accept condition: in_valid && in_ready.
- Latency: a word accepted in cycle t appears on out_data/out_valid of its channel in cycle t+1.
- Data stability:
  - While out_valid[k] = 1 and out_ready[k] = 0, out_data[k] is held constant.
  - When slot k is EMPTY, out_data[k] = 0.
- Independence: channels drain independently. A stalled channel never blocks traffic to other channels.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Out-of-range select: the word is accepted and dropped, and sel_err is set to 1.
  - sel_err clears only on rst.
  - No channel state changes.
- in_valid = 0: in_sel and in_data are ignored and no state changes, apart from drains.

Optional Feature:
- Macro: DX_ROUTE_CNT_EN.
- Defined:
  - Adds output port xfer_cnt, NCH*16 bits.
  - Per-channel 16-bit counter of words delivered (out_valid[k] && out_ready[k]).
  - Counters saturate at 0xFFFF and reset to 0 on rst.
  - Out-of-range drops are not counted.
- Undefined: the port and the counters are absent. All other behaviour is identical.

Decomposition:
- Package dx_pkg:
  - DX_WIDTH_DEF = 32, DX_NCH_DEF = 2, DX_CNT_W = 16.
  - Function dx_sel_w(n) returning max(1, clog2(n)).
- Sub-module dx_slot: one-entry register with load/drain/hold, zero-when-empty data, and the optional counter under the macro.
  - Instantiated NCH times by dx_route.
  - Top level holds only select decode, in_ready mux and sel_err.

Test Plan:
- Reset check: rst high 2 cycles with in_valid = 1 -> out_valid = 0, out_data all zero, sel_err = 0, no slot loaded.
- Basic routing: NCH = 2, out_ready = 2'b11.
  - Send 0xDEADBEEF with sel = 0 -> next cycle out_valid = 2'b01, out_data[0] = 0xDEADBEEF, out_data[1] = 0.
  - Then 0x00001000 with sel = 1 -> out_valid = 2'b10, out_data[1] = 0x00001000.
- Backpressure: NCH = 4, out_ready[2] = 0.
  - Send 0xA to ch2 -> accepted.
  - Second word 0xB to ch2 -> in_ready = 0 and 0xA is held.
  - Word 0xC to ch1 -> in_ready = 1 and delivered next cycle.
  - Raise out_ready[2] -> 0xB accepted in the same cycle 0xA drains.
- Streaming: ch0 with out_ready[0] = 1, 8 back-to-back words 1..8 -> in_ready stays 1 and outputs 1..8 appear on consecutive cycles.
- Bad select: NCH = 3, send sel = 3 with data 0x55 -> in_ready = 1, sel_err = 1 from the next cycle, no out_valid change; sel_err remains set until rst.
- With DX_ROUTE_CNT_EN: deliver 5 words to ch1 -> xfer_cnt[1] = 5, xfer_cnt[0] = 0.
  - Preload the counter near 0xFFFE via 3 deliveries -> it holds at 0xFFFF.
  - rst -> all counters 0.

Source files
------------

// File: rtl/dx_pkg.sv
// rtl/dx_pkg.sv - shared constants, slot state type and select-width helper for dx_route
//
// Purpose:
//   Default parameter values, counter width, slot state encoding and the
//   select-width function used by dx_route and dx_slot.
// Ports: none (package).

package dx_pkg;

    localparam int DX_WIDTH_DEF = 32;
    localparam int DX_NCH_DEF   = 2;
    localparam int DX_CNT_W     = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } dx_slot_state_e;

    // A single channel still needs a one-bit select port, hence the floor of 1.
    function automatic int dx_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dx_slot.sv
// rtl/dx_slot.sv - one-entry output register for a single dx_route channel
//
// Purpose:
//   Holds one word for a consumer. Load, drain and hold are resolved here.
//   Data reads as zero whenever the slot is empty.
//   Optional delivery counter when DX_ROUTE_CNT_EN is defined.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   load   in   an accepted word is routed to this slot this cycle
//   data   in   WIDTH  word to load
//   ready  in   consumer takes the held word
//   valid  out  slot is full
//   q      out  WIDTH  held word, zero when empty
//   cnt    out  DX_CNT_W  saturating count of delivered words (DX_ROUTE_CNT_EN only)

module dx_slot
    import dx_pkg::*;
#(
    parameter int WIDTH = DX_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] q
`ifdef DX_ROUTE_CNT_EN
    ,
    output logic [DX_CNT_W-1:0] cnt
`endif
);

    dx_slot_state_e   state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             drain;

    // The consumer takes the word on any cycle where the slot is full and ready is high.
    assign drain = (state_q == SLOT_FULL) && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load) begin
                    state_d = SLOT_FULL;
                    data_d  = data;
                end
            end
            SLOT_FULL: begin
                // The top only asserts load when full if ready is high as well.
                // A simultaneous drain and load therefore replaces the word in place.
                if (load) begin
                    data_d = data;
                end else if (ready) begin
                    state_d = SLOT_EMPTY;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
                data_d  = '0;
            end
        endcase
    end

    assign valid = (state_q == SLOT_FULL);
    assign q     = data_q;

`ifdef DX_ROUTE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (drain && (cnt != {DX_CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_drain;
    assign unused_drain = drain;
`endif

endmodule

// File: rtl/dx_route.sv
// rtl/dx_route.sv - 1:NCH registered demultiplexer with per-channel valid/ready
//
// Purpose:
//   Steers one WIDTH-bit word to the channel named by in_sel. Each channel has
//   a one-entry dx_slot, so backpressure is per channel. Words with an
//   out-of-range select are accepted, dropped, and set a sticky sel_err.
//   Optional macro DX_ROUTE_CNT_EN adds per-channel 16-bit delivery counters
//   on xfer_cnt.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   source has a word
//   in_ready   out  word accepted this cycle (independent of in_valid)
//   in_data    in   WIDTH  word to route
//   in_sel     in   SEL_W  destination channel
//   out_valid  out  NCH  per-channel full flag
//   out_ready  in   NCH  per-channel consumer ready
//   out_data   out  NCH*WIDTH  channel k at [k*WIDTH +: WIDTH], zero when empty
//   sel_err    out  sticky out-of-range select flag, cleared only by rst
//   xfer_cnt   out  NCH*16  per-channel delivery counters (DX_ROUTE_CNT_EN only)

module dx_route
    import dx_pkg::*;
#(
    parameter  int WIDTH = DX_WIDTH_DEF,
    parameter  int NCH   = DX_NCH_DEF,
    localparam int SEL_W = dx_sel_w(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic                 sel_err
`ifdef DX_ROUTE_CNT_EN
    ,
    output logic [NCH*DX_CNT_W-1:0] xfer_cnt
`endif
);

    logic [NCH-1:0] load;
    logic           in_range;

    // Select decode. An out-of-range select matches no channel, which leaves
    // in_ready at its default of 1 so that the word is swallowed.
    always_comb begin
        load     = '0;
        in_ready = 1'b1;
        in_range = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (in_sel == SEL_W'(k)) begin
                in_range = 1'b1;
                in_ready = !out_valid[k] || out_ready[k];
                load[k]  = in_valid && (!out_valid[k] || out_ready[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (in_valid && !in_range) begin
            sel_err <= 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_slot
        dx_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[g]),
            .data  (in_data),
            .ready (out_ready[g]),
            .valid (out_valid[g]),
            .q     (out_data[g*WIDTH +: WIDTH])
`ifdef DX_ROUTE_CNT_EN
            ,
            .cnt   (xfer_cnt[g*DX_CNT_W +: DX_CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_dx_route.sv
// tb/tb_dx_route.sv - directed, table-driven self-checking bench for dx_route

module tb_dx_route;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // NCH = 2 instance
    logic        v2;
    logic [0:0]  s2;
    logic [31:0] d2;
    logic [1:0]  r2;
    logic        rdy2;
    logic [1:0]  ov2;
    logic [63:0] od2;
    logic        e2;
    // NCH = 3 instance
    logic        v3;
    logic [1:0]  s3;
    logic [31:0] d3;
    logic [2:0]  r3;
    logic        rdy3;
    logic [2:0]  ov3;
    logic [95:0] od3;
    logic        e3;
    // NCH = 4 instance
    logic         v4;
    logic [1:0]   s4;
    logic [31:0]  d4;
    logic [3:0]   r4;
    logic         rdy4;
    logic [3:0]   ov4;
    logic [127:0] od4;
    logic         e4;
`ifdef DX_ROUTE_CNT_EN
    logic [31:0] c2;
    logic [47:0] c3;
    logic [63:0] c4;
`endif

    dx_route #(.WIDTH(32), .NCH(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_data(d2), .in_sel(s2),
        .out_valid(ov2), .out_ready(r2), .out_data(od2), .sel_err(e2)
`ifdef DX_ROUTE_CNT_EN
        , .xfer_cnt(c2)
`endif
    );

    dx_route #(.WIDTH(32), .NCH(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_data(d3), .in_sel(s3),
        .out_valid(ov3), .out_ready(r3), .out_data(od3), .sel_err(e3)
`ifdef DX_ROUTE_CNT_EN
        , .xfer_cnt(c3)
`endif
    );

    dx_route #(.WIDTH(32), .NCH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4), .in_sel(s4),
        .out_valid(ov4), .out_ready(r4), .out_data(od4), .sel_err(e4)
`ifdef DX_ROUTE_CNT_EN
        , .xfer_cnt(c4)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         v;
        logic [1:0]   sel;
        logic [31:0]  d;
        logic [3:0]   ordy;
        logic         exp_rdy;
        logic [3:0]   exp_ov;
        logic [127:0] exp_od;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // NCH=4 table; exp_od is {ch3, ch2, ch1, ch0}, starting from all slots empty.
        vecs[0]  = '{1'b1, 2'd2, 32'hA,    4'b1011, 1'b1, 4'b0100, {32'h0,  32'hA, 32'h0, 32'h0}};
        vecs[1]  = '{1'b1, 2'd2, 32'hB,    4'b1011, 1'b0, 4'b0100, {32'h0,  32'hA, 32'h0, 32'h0}};
        vecs[2]  = '{1'b1, 2'd1, 32'hC,    4'b1011, 1'b1, 4'b0110, {32'h0,  32'hA, 32'hC, 32'h0}};
        vecs[3]  = '{1'b1, 2'd2, 32'hB,    4'b1111, 1'b1, 4'b0100, {32'h0,  32'hB, 32'h0, 32'h0}};
        vecs[4]  = '{1'b0, 2'd3, 32'hFFFF, 4'b1111, 1'b1, 4'b0000, 128'h0};
        vecs[5]  = '{1'b1, 2'd0, 32'h11,   4'b0000, 1'b1, 4'b0001, {32'h0,  32'h0, 32'h0, 32'h11}};
        vecs[6]  = '{1'b1, 2'd3, 32'h33,   4'b0000, 1'b1, 4'b1001, {32'h33, 32'h0, 32'h0, 32'h11}};
        vecs[7]  = '{1'b1, 2'd0, 32'h22,   4'b0000, 1'b0, 4'b1001, {32'h33, 32'h0, 32'h0, 32'h11}};
        vecs[8]  = '{1'b0, 2'd0, 32'h0,    4'b0001, 1'b1, 4'b1000, {32'h33, 32'h0, 32'h0, 32'h0}};
        vecs[9]  = '{1'b1, 2'd3, 32'h44,   4'b1000, 1'b1, 4'b1000, {32'h44, 32'h0, 32'h0, 32'h0}};
        vecs[10] = '{1'b0, 2'd1, 32'h0,    4'b1000, 1'b1, 4'b0000, 128'h0};

        // Reset with in_valid high on every instance.
        rst = 1'b1;
        v2 = 1'b1; s2 = 1'b0; d2 = 32'h1234; r2 = '1;
        v3 = 1'b1; s3 = 2'd0; d3 = 32'h1234; r3 = '1;
        v4 = 1'b1; s4 = 2'd0; d4 = 32'h1234; r4 = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ov2", ov2, 0); chk("rst_od2", od2, 0); chk("rst_err2", e2, 0);
        chk("rst_ov3", ov3, 0); chk("rst_od3", od3, 0); chk("rst_err3", e3, 0);
        chk("rst_ov4", ov4, 0); chk("rst_od4", od4, 0); chk("rst_err4", e4, 0);
`ifdef DX_ROUTE_CNT_EN
        chk("rst_cnt4", c4, 0);
`endif
        rst = 1'b0; v2 = 1'b0; v3 = 1'b0; v4 = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ov2", ov2, 0); chk("post_rst_ov3", ov3, 0); chk("post_rst_ov4", ov4, 0);

        // Table vectors on the NCH=4 instance.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            v4 = vecs[i].v; s4 = vecs[i].sel; d4 = vecs[i].d; r4 = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_rdy", i), rdy4, vecs[i].exp_rdy);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_ov", i), ov4, vecs[i].exp_ov);
            chk($sformatf("vec%0d_od", i), od4, vecs[i].exp_od);
        end

        // Reset in the middle of operation drops the buffered word.
        @(negedge clk); v4 = 1'b1; s4 = 2'd0; d4 = 32'h77; r4 = 4'b0000;
        @(posedge clk); #1; chk("midrst_load", ov4, 4'b0001);
        @(negedge clk); v4 = 1'b0; rst = 1'b1;
        @(posedge clk); #1; chk("midrst_ov", ov4, 0); chk("midrst_od", od4, 0);
        @(negedge clk); rst = 1'b0; r4 = '1;
        @(posedge clk); #1; chk("midrst_after", ov4, 0);

        // Basic routing, NCH=2.
        @(negedge clk); v2 = 1'b1; s2 = 1'b0; d2 = 32'hDEADBEEF; r2 = 2'b11;
        @(posedge clk); #1;
        chk("basic0_ov", ov2, 2'b01); chk("basic0_od", od2, {32'h0, 32'hDEADBEEF});
        @(negedge clk); s2 = 1'b1; d2 = 32'h00001000;
        @(posedge clk); #1;
        chk("basic1_ov", ov2, 2'b10); chk("basic1_od", od2, {32'h00001000, 32'h0});

        // Back-to-back streaming into ch0.
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); v2 = 1'b1; s2 = 1'b0; d2 = i; r2 = 2'b11;
            #1; chk($sformatf("stream%0d_rdy", i), rdy2, 1'b1);
            @(posedge clk); #1;
            chk($sformatf("stream%0d_od", i), od2[31:0], i);
            chk($sformatf("stream%0d_ov", i), ov2[0], 1'b1);
        end
        @(negedge clk); v2 = 1'b0;
        @(posedge clk); #1; chk("stream_end_ov", ov2, 0);

        // Out-of-range select on NCH=3.
        @(negedge clk); v3 = 1'b1; s3 = 2'd3; d3 = 32'h55; r3 = 3'b000;
        #1; chk("badsel_rdy", rdy3, 1'b1);
        @(posedge clk); #1;
        chk("badsel_err", e3, 1'b1); chk("badsel_ov", ov3, 0); chk("badsel_od", od3, 0);
        @(negedge clk); s3 = 2'd0; d3 = 32'h66;
        @(posedge clk); #1;
        chk("badsel_ch0_ov", ov3, 3'b001); chk("badsel_ch0_od", od3[31:0], 32'h66);
        @(negedge clk); v3 = 1'b0; r3 = '1;
        repeat (3) @(posedge clk); #1;
        chk("badsel_sticky", e3, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; chk("badsel_clear", e3, 1'b0);
        @(negedge clk); rst = 1'b0;

`ifdef DX_ROUTE_CNT_EN
        // Five deliveries to ch1 of NCH=2.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); v2 = 1'b1; s2 = 1'b1; d2 = i; r2 = 2'b11;
        end
        @(negedge clk); v2 = 1'b0;
        @(posedge clk); #1;
        chk("cnt_ch1_5", c2[31:16], 16'd5); chk("cnt_ch0_0", c2[15:0], 16'd0);
        // Bring ch1 to 0xFFFE, then three more deliveries saturate at 0xFFFF.
        for (int i = 0; i < 65529; i++) begin
            @(negedge clk); v2 = 1'b1; s2 = 1'b1; d2 = i;
        end
        @(negedge clk); v2 = 1'b0;
        @(posedge clk); #1; chk("cnt_fffe", c2[31:16], 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); v2 = 1'b1; s2 = 1'b1; d2 = i;
        end
        @(negedge clk); v2 = 1'b0;
        @(posedge clk); #1; chk("cnt_sat", c2[31:16], 16'hFFFF);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; chk("cnt_rst", c2, 0);
        @(negedge clk); rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
